// File: rtl/pipe_pkg.sv
// Shared constants for the CPU inter-stage pipeline registers.
// Control-field bit positions and default payload widths.
package pipe_pkg;

  localparam int CTRL_WREG     = 0;
  localparam int CTRL_M2REG    = 1;
  localparam int CTRL_WMEM     = 2;
  localparam int CTRL_ALUIMM   = 3;
  localparam int CTRL_SHIFT    = 4;
  localparam int CTRL_JAL      = 5;
  localparam int CTRL_ALUC_LSB = 6;

  localparam int CTRL_W_DEFAULT   = 10;
  localparam int DATA_W_DEFAULT   = 133;
  localparam int CTRL_NOP_DEFAULT = 0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear wins over increment; the count holds at all-ones.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Ready/valid inter-stage pipeline register with optional skid entry,
// synchronous flush and bubble/stall performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W   = CTRL_W_DEFAULT,
  parameter int                DATA_W   = DATA_W_DEFAULT,
  parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEFAULT),
  parameter bit                SKID     = 1'b1,
  parameter int                CNT_W    = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              mv;
  logic [CTRL_W-1:0] mc;
  logic [DATA_W-1:0] md;
  logic              sv;
  logic [CTRL_W-1:0] sc;
  logic [DATA_W-1:0] sd;

  logic acc_in;
  logic acc_out;
  logic m_free;

  assign acc_in  = in_valid & in_ready;
  assign acc_out = mv & out_ready;
  assign m_free  = ~mv | acc_out;

  assign out_valid = mv;
  assign out_ctrl  = mv ? mc : CTRL_NOP;
  assign out_data  = md;

  // Main entry: refilled from the skid entry first to keep arrival order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mv <= 1'b0;
      mc <= CTRL_NOP;
      md <= '0;
    end else if (flush) begin
      mv <= 1'b0;
    end else if (m_free) begin
      if (sv) begin
        mv <= 1'b1;
        mc <= sc;
        md <= sd;
      end else if (acc_in) begin
        mv <= 1'b1;
        mc <= in_ctrl;
        md <= in_data;
      end else begin
        mv <= 1'b0;
      end
    end
  end

  generate
    if (SKID) begin : g_skid
      assign in_ready = ~sv;

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          sv <= 1'b0;
          sc <= CTRL_NOP;
          sd <= '0;
        end else if (flush) begin
          sv <= 1'b0;
        end else if (m_free) begin
          sv <= 1'b0;
        end else if (acc_in) begin
          sv <= 1'b1;
          sc <= in_ctrl;
          sd <= in_data;
        end
      end
    end else begin : g_noskid
      assign in_ready = ~mv | out_ready;
      assign sv       = 1'b0;
      assign sc       = CTRL_NOP;
      assign sd       = '0;
    end
  endgenerate

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble (
    .clock  (clock),
    .resetn (resetn),
    .clr    (cnt_clr),
    .inc    (out_ready & ~mv),
    .count  (bubble_cnt)
  );

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall (
    .clock  (clock),
    .resetn (resetn),
    .clr    (cnt_clr),
    .inc    (mv & ~out_ready),
    .count  (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid and non-skid instances,
// scoreboard on the skid instance's output stream.
module tb_pipe_stage_reg;

  localparam int CW = 10;
  localparam int DW = 133;
  localparam int NW = 4;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic          flush = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [NW-1:0] bubble_cnt;
  logic [NW-1:0] stall_cnt;

  logic          b_in_valid = 1'b0;
  logic          b_in_ready;
  logic [CW-1:0] b_in_ctrl = '0;
  logic [DW-1:0] b_in_data = '0;
  logic          b_out_valid;
  logic          b_out_ready = 1'b0;
  logic [CW-1:0] b_out_ctrl;
  logic [DW-1:0] b_out_data;
  logic [NW-1:0] b_bubble_cnt;
  logic [NW-1:0] b_stall_cnt;

  pipe_stage_reg #(
    .CTRL_W (CW), .DATA_W (DW), .CTRL_NOP ('0), .SKID (1'b1), .CNT_W (NW)
  ) u_dut (
    .clock (clock), .resetn (resetn),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_ctrl (in_ctrl), .in_data (in_data),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_ctrl (out_ctrl), .out_data (out_data),
    .flush (flush), .cnt_clr (cnt_clr),
    .bubble_cnt (bubble_cnt), .stall_cnt (stall_cnt)
  );

  pipe_stage_reg #(
    .CTRL_W (CW), .DATA_W (DW), .CTRL_NOP ('0), .SKID (1'b0), .CNT_W (NW)
  ) u_dut0 (
    .clock (clock), .resetn (resetn),
    .in_valid (b_in_valid), .in_ready (b_in_ready),
    .in_ctrl (b_in_ctrl), .in_data (b_in_data),
    .out_valid (b_out_valid), .out_ready (b_out_ready),
    .out_ctrl (b_out_ctrl), .out_data (b_out_data),
    .flush (1'b0), .cnt_clr (1'b0),
    .bubble_cnt (b_bubble_cnt), .stall_cnt (b_stall_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [CW+DW-1:0] sb[$];

  function automatic logic [DW-1:0] mkdata(input logic [CW-1:0] c);
    logic [63:0] hi;
    hi = 64'hC0DE_0000_0000_0000 | 64'(c);
    return {c[4:0], hi, 64'(~c)};
  endfunction

  task automatic chk(input string tag,
                     input logic [CW+DW-1:0] obs,
                     input logic [CW+DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c);
    in_valid = v;
    in_ctrl  = c;
    in_data  = mkdata(c);
  endtask

  // One clock: sample pre-edge handshakes, then step past the edge.
  task automatic cyc();
    logic [CW+DW-1:0] e;
    @(negedge clock);
    if (!flush && out_valid && out_ready) begin
      n_chk++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_underflow observed=%0h expected=none", out_ctrl);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_out", {out_ctrl, out_data}, e);
      end
    end
    if (!flush && in_valid && in_ready)
      sb.push_back({in_ctrl, in_data});
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Reset while both entries are full
    out_ready = 1'b0;
    drive(1'b1, 10'h03A);
    cyc();
    drive(1'b1, 10'h03B);
    cyc();
    chk("full_valid", out_valid, 1);
    chk("full_ready", in_ready, 0);
    chk("full_ctrl", out_ctrl, 10'h03A);
    drive(1'b0, 10'h000);
    resetn = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ctrl", out_ctrl, 0);
    chk("arst_data", out_data, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_bub", bubble_cnt, 0);
    chk("arst_stall", stall_cnt, 0);
    sb.delete();
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Streaming 1..8, one per cycle
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, CW'(k));
      cyc();
      chk("strm_valid", out_valid, 1);
      chk("strm_ctrl", out_ctrl, CW'(k));
    end
    drive(1'b0, 10'h000);
    cyc();
    chk("strm_bub", bubble_cnt, 1);
    chk("strm_stall", stall_cnt, 0);
    out_ready = 1'b0;
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    chk("clr_bub", bubble_cnt, 0);

    // Backpressure through the skid entry
    out_ready = 1'b1;
    drive(1'b1, 10'h0A1);
    cyc();
    out_ready = 1'b0;
    drive(1'b1, 10'h0B2);
    cyc();
    chk("bp_ready_lo", in_ready, 0);
    drive(1'b1, 10'h0C3);
    cyc();
    cyc();
    chk("bp_hold_ctrl", out_ctrl, 10'h0A1);
    out_ready = 1'b1;
    cyc();
    chk("bp_ctrl_b", out_ctrl, 10'h0B2);
    chk("bp_ready_hi", in_ready, 1);
    cyc();
    chk("bp_ctrl_c", out_ctrl, 10'h0C3);
    drive(1'b0, 10'h000);
    cyc();
    chk("bp_stall", stall_cnt, 3);
    chk("bp_bub", bubble_cnt, 1);
    chk("bp_sb_empty", sb.size(), 0);

    // Flush with both entries full and input offered
    out_ready = 1'b0;
    drive(1'b1, 10'h111);
    cyc();
    drive(1'b1, 10'h122);
    cyc();
    chk("fl_full", {out_valid, in_ready}, 2'b10);
    flush = 1'b1;
    drive(1'b1, 10'h133);
    cyc();
    flush = 1'b0;
    drive(1'b0, 10'h000);
    sb.delete();
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", out_ctrl, 0);
    chk("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    cyc();
    chk("fl_stay_empty", out_valid, 0);
    // Flush discards input accepted the same cycle
    flush = 1'b1;
    drive(1'b1, 10'h144);
    cyc();
    flush = 1'b0;
    drive(1'b0, 10'h000);
    chk("fl_in_drop", out_valid, 0);

    // Bubble counter saturation
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    chk("sat_clr", bubble_cnt, 0);
    for (int k = 0; k < 10; k++) cyc();
    chk("sat_10", bubble_cnt, 10);
    for (int k = 0; k < 10; k++) cyc();
    chk("sat_hold", bubble_cnt, 15);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    chk("sat_clr_win", bubble_cnt, 0);
    cyc();
    chk("sat_resume", bubble_cnt, 1);
    out_ready = 1'b0;

    // Non-skid instance: combinational in_ready
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_ctrl   = 10'h201;
    b_in_data   = mkdata(10'h201);
    @(posedge clock);
    #1;
    chk("ns_valid", b_out_valid, 1);
    chk("ns_ready_lo", b_in_ready, 0);
    b_out_ready = 1'b1;
    b_in_ctrl   = 10'h202;
    b_in_data   = mkdata(10'h202);
    #1;
    chk("ns_ready_hi", b_in_ready, 1);
    @(posedge clock);
    #1;
    chk("ns_repl_valid", b_out_valid, 1);
    chk("ns_repl", {b_out_ctrl, b_out_data},
        {10'h202, mkdata(10'h202)});
    b_in_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("ns_drain", b_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the pipelined CPU. It is the next-generation ID/EXE, EXE/MEM and MEM/WB register.
- Payload is split into a control field and a data field.
- Ready/valid handshake replaces the single stall-enable input.
- Optional skid buffer gives a registered in_ready.
- Synchronous flush.
- Saturating bubble and stall performance counters.

Parameters:
CTRL_W, 10, control-field width (wreg, m2reg, wmem, aluimm, shift, jal, aluc[3:0]).
DATA_W, 133, data-field width (rn[4:0], pc4, a, b, imm).
CTRL_NOP, 0, control value presented when the stage holds no valid instruction.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
CNT_W, 16, performance counter width.

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  upstream stage presents an instruction
in_ready  out  1  stage can accept an instruction this cycle
in_ctrl  in  CTRL_W  upstream control field
in_data  in  DATA_W  upstream data field
out_valid  out  1  stage holds a valid instruction
out_ready  in  1  downstream stage accepts this cycle
out_ctrl  out  CTRL_W  control field, forced to CTRL_NOP when not valid
out_data  out  DATA_W  data field, undefined content when not valid
flush  in  1  synchronous kill of all held instructions (branch/jump redirect)
cnt_clr  in  1  synchronous clear of both counters
bubble_cnt  out  CNT_W  cycles with out_ready=1 and out_valid=0
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (resetn=0, asynchronous):
  - mv=0, sv=0; mc=sc=CTRL_NOP; md=sd=0; counters=0.
  - Resulting outputs: out_valid=0, out_ctrl=CTRL_NOP, out_data=0, in_ready=1.
- Storage:
  - Main entry: M (mv, mc, md).
  - Skid entry: S (sv, sc, sd), present only when SKID=1.
- Definitions: acc_in = in_valid & in_ready; acc_out = mv & out_ready.
- Output ports:
  - out_valid = mv.
  - out_ctrl = mv ? mc : CTRL_NOP. This guarantees a bubble never writes regfile or memory.
  - out_data = md.
- in_ready:
  - SKID=1: in_ready = ~sv, purely registered.
  - SKID=0: in_ready = ~mv | out_ready.
- Latency: one cycle from acc_in to out_valid. Sustained throughput is one instruction per cycle.
- Update on each rising edge, in priority order:
  1. flush=1: mv<=0, sv<=0. Any acc_in this cycle is discarded. Data registers may hold stale values.
  2. M free (~mv | acc_out):
     - if sv: M<=S, sv<=0;
     - else if acc_in: M<=input, mv<=1;
     - else mv<=0.
  3. M occupied and held (mv & ~out_ready) with acc_in (SKID=1 only): S<=input, sv<=1.
- Ordering: instructions leave in arrival order. S always drains into M before any new input is accepted.
- Simultaneous events:
  - acc_out and acc_in with sv=0: M replaced in the same edge, no bubble.
  - flush overrides all transfers.
  - cnt_clr has priority over counter increments.
- Counters:
  - Each increments by 1 per qualifying cycle and saturates at all-ones (no wrap).
  - Counting is independent of flush (the cycle is evaluated on pre-edge state).
- SKID=0: S and its logic are absent; sv is treated as constant 0.

Decomposition:
- Shared package pipe_pkg:
  - control bit-position constants (CTRL_WREG=0, CTRL_M2REG=1, CTRL_WMEM=2, CTRL_ALUIMM=3, CTRL_SHIFT=4, CTRL_JAL=5, CTRL_ALUC_LSB=6);
  - CTRL_W_DEFAULT=10, DATA_W_DEFAULT=133, CTRL_NOP_DEFAULT=0.
- One sub-module: pipe_sat_counter (CNT_W; ports clock, resetn, clr, inc, count), instantiated twice.

Test Plan:
1. Reset mid-stream: assert resetn=0 with mv=sv=1 -> out_valid=0, out_ctrl=0, in_ready=1 immediately, before the next edge. Counters read 0.
2. Streaming: in_valid=1, out_ready=1, in_ctrl = 0x001..0x008 on consecutive cycles -> out_ctrl = 0x001..0x008 one cycle later, no gaps. bubble_cnt and stall_cnt unchanged.
3. Backpressure, SKID=1: send A, B, C; drop out_ready for 3 cycles from the cycle after A enters -> B captured in S, in_ready=0, C held upstream. Release out_ready -> output sequence A, B, C. stall_cnt=3.
4. Flush while full: mv=sv=1, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=CTRL_NOP, in_ready=1. Neither held instruction nor input appears at output.
5. Counter saturation, CNT_W=4: out_ready=1, in_valid=0 for 20 cycles -> bubble_cnt reaches 15 and stays at 15. Pulse cnt_clr together with an increment -> bubble_cnt=0.
6. SKID=0: mv=1, out_ready=0 -> in_ready=0. Raise out_ready and in_valid in the same cycle -> M replaced at the next edge, out_valid stays 1.
